// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register: one-cycle transport of the decoded instruction into EX,
// with flush/hold control, load-use bubble insertion and a saturating bubble counter.
module id_ex_stage_register (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_data1,
  input  logic [31:0] id_data2,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rd,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [5:0]  id_alu_signal,
  input  logic        id_reg_file_write,
  input  logic [2:0]  id_main_mem_write,
  input  logic [3:0]  id_main_mem_read,
  input  logic [3:0]  id_branch_control,
  input  logic [1:0]  id_reg_write_select,
  input  logic        id_oparand_1_select,
  input  logic        id_oparand_2_select,
  input  logic        flush,
  input  logic        hold,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_data1,
  output logic [31:0] ex_data2,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [5:0]  ex_alu_signal,
  output logic        ex_reg_file_write,
  output logic [2:0]  ex_main_mem_write,
  output logic [3:0]  ex_main_mem_read,
  output logic [3:0]  ex_branch_control,
  output logic [1:0]  ex_reg_write_select,
  output logic        ex_oparand_1_select,
  output logic        ex_oparand_2_select,
  output logic        stall_out,
  output logic [15:0] bubble_count
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned ALU_W = 6;
  localparam int unsigned MW_W  = 3;
  localparam int unsigned MR_W  = 4;
  localparam int unsigned BR_W  = 4;
  localparam int unsigned RWS_W = 2;
  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  data1;
    logic [XLEN-1:0]  data2;
    logic [XLEN-1:0]  imm;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [ALU_W-1:0] alu_signal;
    logic             reg_file_write;
    logic [MW_W-1:0]  main_mem_write;
    logic [MR_W-1:0]  main_mem_read;
    logic [BR_W-1:0]  branch_control;
    logic [RWS_W-1:0] reg_write_select;
    logic             oparand_1_select;
    logic             oparand_2_select;
  } ex_word_t;

  ex_word_t         ex_q, ex_d, id_word;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             hazard_c;

  // Load in EX whose destination feeds a source of the valid ID instruction.
  always_comb begin
    id_word = '{valid: id_valid, pc: id_pc, data1: id_data1, data2: id_data2,
                imm: id_imm, rd: id_rd, rs1: id_rs1, rs2: id_rs2,
                alu_signal: id_alu_signal, reg_file_write: id_reg_file_write,
                main_mem_write: id_main_mem_write, main_mem_read: id_main_mem_read,
                branch_control: id_branch_control, reg_write_select: id_reg_write_select,
                oparand_1_select: id_oparand_1_select, oparand_2_select: id_oparand_2_select};
    hazard_c = ex_q.valid & ex_q.main_mem_read[MR_W-1] & (ex_q.rd != REG_W'(0)) &
               ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2)) & id_valid;
    stall_out = hazard_c & ~flush;
  end

  // Priority: flush > hold > load-use bubble > capture; counter saturates.
  always_comb begin
    ex_d    = ex_q;
    cnt_d   = cnt_q;
    cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    if (flush) begin
      ex_d  = '0;
      cnt_d = cnt_inc;
    end else if (hold) begin
      ex_d  = ex_q;
    end else if (hazard_c) begin
      ex_d  = '0;
      cnt_d = cnt_inc;
    end else begin
      ex_d  = id_word;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid            = ex_q.valid;
  assign ex_pc               = ex_q.pc;
  assign ex_data1            = ex_q.data1;
  assign ex_data2            = ex_q.data2;
  assign ex_imm              = ex_q.imm;
  assign ex_rd               = ex_q.rd;
  assign ex_rs1              = ex_q.rs1;
  assign ex_rs2              = ex_q.rs2;
  assign ex_alu_signal       = ex_q.alu_signal;
  assign ex_reg_file_write   = ex_q.reg_file_write;
  assign ex_main_mem_write   = ex_q.main_mem_write;
  assign ex_main_mem_read    = ex_q.main_mem_read;
  assign ex_branch_control   = ex_q.branch_control;
  assign ex_reg_write_select = ex_q.reg_write_select;
  assign ex_oparand_1_select = ex_q.oparand_1_select;
  assign ex_oparand_2_select = ex_q.oparand_2_select;
  assign bubble_count        = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Bench for id_ex_stage_register: directed scenarios plus randomized traffic
// checked against a per-edge behavioural model of the ID/EX register.
module tb_id_ex_stage_register;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_pc = '0, id_data1 = '0, id_data2 = '0, id_imm = '0;
  logic [4:0]  id_rd = '0, id_rs1 = '0, id_rs2 = '0;
  logic [5:0]  id_alu_signal = '0;
  logic        id_reg_file_write = 1'b0;
  logic [2:0]  id_main_mem_write = '0;
  logic [3:0]  id_main_mem_read = '0, id_branch_control = '0;
  logic [1:0]  id_reg_write_select = '0;
  logic        id_oparand_1_select = 1'b0, id_oparand_2_select = 1'b0;
  logic        flush = 1'b0, hold = 1'b0;

  logic        ex_valid;
  logic [31:0] ex_pc, ex_data1, ex_data2, ex_imm;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic [5:0]  ex_alu_signal;
  logic        ex_reg_file_write;
  logic [2:0]  ex_main_mem_write;
  logic [3:0]  ex_main_mem_read, ex_branch_control;
  logic [1:0]  ex_reg_write_select;
  logic        ex_oparand_1_select, ex_oparand_2_select;
  logic        stall_out;
  logic [15:0] bubble_count;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, data1, data2, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [5:0]  alu;
    logic        rfw;
    logic [2:0]  mw;
    logic [3:0]  mr, br;
    logic [1:0]  rws;
    logic        op1, op2;
  } word_t;

  word_t dut_word;
  word_t m;
  int    m_cnt;
  int    checks = 0;
  int    errors = 0;

  always #5 CLK = ~CLK;

  id_ex_stage_register dut (
    .CLK(CLK), .RESET(RESET),
    .id_valid(id_valid), .id_pc(id_pc), .id_data1(id_data1), .id_data2(id_data2),
    .id_imm(id_imm), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_alu_signal(id_alu_signal), .id_reg_file_write(id_reg_file_write),
    .id_main_mem_write(id_main_mem_write), .id_main_mem_read(id_main_mem_read),
    .id_branch_control(id_branch_control), .id_reg_write_select(id_reg_write_select),
    .id_oparand_1_select(id_oparand_1_select), .id_oparand_2_select(id_oparand_2_select),
    .flush(flush), .hold(hold),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_data1(ex_data1), .ex_data2(ex_data2),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_alu_signal(ex_alu_signal), .ex_reg_file_write(ex_reg_file_write),
    .ex_main_mem_write(ex_main_mem_write), .ex_main_mem_read(ex_main_mem_read),
    .ex_branch_control(ex_branch_control), .ex_reg_write_select(ex_reg_write_select),
    .ex_oparand_1_select(ex_oparand_1_select), .ex_oparand_2_select(ex_oparand_2_select),
    .stall_out(stall_out), .bubble_count(bubble_count)
  );

  assign dut_word = '{valid: ex_valid, pc: ex_pc, data1: ex_data1, data2: ex_data2,
                      imm: ex_imm, rd: ex_rd, rs1: ex_rs1, rs2: ex_rs2,
                      alu: ex_alu_signal, rfw: ex_reg_file_write, mw: ex_main_mem_write,
                      mr: ex_main_mem_read, br: ex_branch_control, rws: ex_reg_write_select,
                      op1: ex_oparand_1_select, op2: ex_oparand_2_select};

  function automatic word_t id_word();
    return '{valid: id_valid, pc: id_pc, data1: id_data1, data2: id_data2,
             imm: id_imm, rd: id_rd, rs1: id_rs1, rs2: id_rs2,
             alu: id_alu_signal, rfw: id_reg_file_write, mw: id_main_mem_write,
             mr: id_main_mem_read, br: id_branch_control, rws: id_reg_write_select,
             op1: id_oparand_1_select, op2: id_oparand_2_select};
  endfunction

  function automatic bit exp_hazard();
    return m.valid && m.mr[3] && (m.rd != 0) && (m.rd == id_rs1 || m.rd == id_rs2) && id_valid;
  endfunction

  function automatic bit exp_stall();
    return exp_hazard() && !flush;
  endfunction

  // Reference model of one clock edge, evaluated with pre-edge inputs and state.
  task automatic model_edge();
    if (flush) begin
      m = '0;
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
    end else if (hold) begin
      m = m;
    end else if (exp_hazard()) begin
      m = '0;
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
    end else begin
      m = id_word();
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic rand_id(input bit small_regs);
    id_valid = 1'($urandom);
    id_pc = $urandom; id_data1 = $urandom; id_data2 = $urandom; id_imm = $urandom;
    id_rd  = small_regs ? 5'($urandom_range(0, 3)) : 5'($urandom);
    id_rs1 = small_regs ? 5'($urandom_range(0, 3)) : 5'($urandom);
    id_rs2 = small_regs ? 5'($urandom_range(0, 3)) : 5'($urandom);
    id_alu_signal = 6'($urandom); id_reg_file_write = 1'($urandom);
    id_main_mem_write = 3'($urandom); id_main_mem_read = 4'($urandom);
    id_branch_control = 4'($urandom); id_reg_write_select = 2'($urandom);
    id_oparand_1_select = 1'($urandom); id_oparand_2_select = 1'($urandom);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2 RESET = 1'b0;
    m = '0;
    m_cnt = 0;
    #1;
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    flush = 1'b0; hold = 1'b0;
    rand_id(1'b0);
    #3;
    checks++;
    if (dut_word !== word_t'(0) || bubble_count !== 16'h0 || stall_out !== 1'b0) begin
      errors++;
      $display("FAIL reset: word=%h cnt=%h stall=%b required all zero", dut_word, bubble_count, stall_out);
    end
    m = '0; m_cnt = 0;
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic test_capture();
    @(negedge CLK);
    rand_id(1'b0);
    id_valid = 1'b1; id_pc = 32'h0000_0100; id_alu_signal = 6'b001000;
    flush = 1'b0; hold = 1'b0;
    #1;
    checks++;
    if (stall_out !== exp_stall()) begin
      errors++;
      $display("FAIL capture_stall: got %b required %b", stall_out, exp_stall());
    end
    tick();
    checks++;
    if (ex_pc !== 32'h100 || ex_alu_signal !== 6'b001000 || ex_valid !== 1'b1 || stall_out !== 1'b0) begin
      errors++;
      $display("FAIL capture: pc=%h alu=%b valid=%b stall=%b required 100/001000/1/0",
               ex_pc, ex_alu_signal, ex_valid, stall_out);
    end
    checks++;
    if (dut_word !== m) begin
      errors++;
      $display("FAIL capture_word: got %h required %h", dut_word, m);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    rand_id(1'b0);
    id_valid = 1'b1; id_main_mem_read = 4'b1010; id_rd = 5'd5;
    flush = 1'b0; hold = 1'b0;
    tick();
    @(negedge CLK);
    rand_id(1'b0);
    id_valid = 1'b1; id_rs1 = 5'd7; id_rs2 = 5'd5; id_rd = 5'd3; id_main_mem_read = 4'b0000;
    #1;
    checks++;
    if (stall_out !== 1'b1) begin
      errors++;
      $display("FAIL load_use_stall: got %b required 1", stall_out);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_reg_file_write !== 1'b0 || bubble_count !== 16'd1 || dut_word !== word_t'(0)) begin
      errors++;
      $display("FAIL load_use_bubble: valid=%b rfw=%b cnt=%0d word=%h required 0/0/1/0",
               ex_valid, ex_reg_file_write, bubble_count, dut_word);
    end
    checks++;
    if (stall_out !== 1'b0) begin
      errors++;
      $display("FAIL load_use_release: stall got %b required 0", stall_out);
    end
    tick();
    checks++;
    if (dut_word !== id_word() || ex_rs2 !== 5'd5 || bubble_count !== 16'd1) begin
      errors++;
      $display("FAIL load_use_capture: got %h cnt=%0d required %h cnt=1", dut_word, bubble_count, id_word());
    end
  endtask

  task automatic test_no_false_hazard();
    @(negedge CLK);
    rand_id(1'b0);
    id_valid = 1'b1; id_main_mem_read = 4'b1111; id_rd = 5'd0;
    flush = 1'b0; hold = 1'b0;
    tick();
    @(negedge CLK);
    rand_id(1'b0);
    id_valid = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd9; id_main_mem_read = 4'b0111;
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      errors++;
      $display("FAIL rd0_stall: got %b required 0", stall_out);
    end
    tick();
    checks++;
    if (dut_word !== id_word()) begin
      errors++;
      $display("FAIL rd0_capture: got %h required %h", dut_word, id_word());
    end
    @(negedge CLK);
    rand_id(1'b0);
    id_valid = 1'b1; id_rs1 = 5'd9; id_rs2 = 5'd1;
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      errors++;
      $display("FAIL nonload_stall: got %b required 0", stall_out);
    end
    tick();
    checks++;
    if (dut_word !== id_word()) begin
      errors++;
      $display("FAIL nonload_capture: got %h required %h", dut_word, id_word());
    end
  endtask

  task automatic test_priority();
    int prev;
    @(negedge CLK);
    rand_id(1'b0);
    id_valid = 1'b1; id_main_mem_read = 4'b1000; id_rd = 5'd5;
    flush = 1'b0; hold = 1'b0;
    tick();
    @(negedge CLK);
    rand_id(1'b0);
    id_valid = 1'b1; id_rs1 = 5'd5;
    flush = 1'b1; hold = 1'b1;
    prev = m_cnt;
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      errors++;
      $display("FAIL prio_stall: got %b required 0", stall_out);
    end
    tick();
    checks++;
    if (dut_word !== word_t'(0) || int'(bubble_count) !== prev + 1) begin
      errors++;
      $display("FAIL prio_bubble: word=%h cnt=%0d required 0 cnt=%0d", dut_word, bubble_count, prev + 1);
    end
    @(negedge CLK);
    flush = 1'b0; hold = 1'b0;
    rand_id(1'b0);
    id_valid = 1'b1; id_main_mem_read = 4'b0000;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      rand_id(1'b0);
      hold = 1'b1;
      tick();
      checks++;
      if (dut_word !== m || int'(bubble_count) !== m_cnt) begin
        errors++;
        $display("FAIL hold_%0d: got %h cnt=%0d required %h cnt=%0d", i, dut_word, bubble_count, m, m_cnt);
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      rand_id(1'b1);
      if ($urandom_range(0, 2) == 0) id_main_mem_read[3] = 1'b1;
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 6) == 0);
      #1;
      checks++;
      if (stall_out !== exp_stall()) begin
        errors++;
        $display("FAIL rand_stall[%0d]: got %b required %b", i, stall_out, exp_stall());
      end
      tick();
      checks++;
      if (dut_word !== m || int'(bubble_count) !== m_cnt) begin
        errors++;
        $display("FAIL rand_word[%0d]: got %h cnt=%0d required %h cnt=%0d", i, dut_word, bubble_count, m, m_cnt);
      end
    end
    @(negedge CLK);
    flush = 1'b0; hold = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    flush = 1'b1; hold = 1'b0;
    for (int i = 0; i < 65534; i++) tick();
    checks++;
    if (bubble_count !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_preload: got %h required FFFE", bubble_count);
    end
    tick();
    checks++;
    if (bubble_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_first: got %h required FFFF", bubble_count);
    end
    tick();
    checks++;
    if (bubble_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: got %h required FFFF", bubble_count);
    end
    @(negedge CLK);
    flush = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge CLK);
    rand_id(1'b0);
    id_valid = 1'b1; flush = 1'b0; hold = 1'b0;
    tick();
    @(negedge CLK);
    hold = 1'b1;
    rand_id(1'b0);
    #2 RESET = 1'b0;
    #1;
    checks++;
    if (dut_word !== word_t'(0) || bubble_count !== 16'h0 || stall_out !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: word=%h cnt=%h stall=%b required all zero", dut_word, bubble_count, stall_out);
    end
    m = '0; m_cnt = 0;
    @(negedge CLK);
    RESET = 1'b1; hold = 1'b0;
    rand_id(1'b0);
    id_valid = 1'b1;
    tick();
    checks++;
    if (dut_word !== m || dut_word !== id_word() || bubble_count !== 16'h0) begin
      errors++;
      $display("FAIL post_reset_capture: got %h cnt=%0d required %h cnt=0", dut_word, bubble_count, m);
    end
  endtask

  initial begin
    m = '0;
    m_cnt = 0;
    test_reset();
    test_capture();
    test_load_use();
    test_no_false_hazard();
    test_priority();
    test_random();
    test_async_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_register.md
ID_EX_STAGE_REGISTER -- requirements
Module: id_ex_stage_register

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: CLK in 1, rising-edge clock; RESET in 1, asynchronous active-low reset.
REQ-002 The block SHALL take ID-stage inputs: id_valid in 1, decode slot holds a real instruction; id_pc in 32; id_data1 in 32; id_data2 in 32; id_imm in 32; id_rd in 5; id_rs1 in 5; id_rs2 in 5.
REQ-003 The block SHALL take decoded control inputs from the decoder: id_alu_signal in 6; id_reg_file_write in 1; id_main_mem_write in 3; id_main_mem_read in 4; id_branch_control in 4; id_reg_write_select in 2; id_oparand_1_select in 1; id_oparand_2_select in 1.
REQ-004 The block SHALL take pipeline control inputs: flush in 1, branch/jump taken in EX, kill the ID instruction; hold in 1, downstream busy, freeze the register.
REQ-005 The block SHALL drive ex_* outputs with the same names and widths as every id_* input in REQ-002/003, plus ex_valid out 1.
REQ-006 The block SHALL drive stall_out out 1, a load-use hazard indication that holds the PC and the IF/ID register.
REQ-007 The block SHALL drive bubble_count out 16, a saturating count of inserted bubbles.

Function
REQ-008 Each CLK edge SHALL perform exactly one action, chosen by priority: flush > hold > load-use bubble > capture.
REQ-009 Capture SHALL load every ex_* output from the matching id_* input; ex_valid <= id_valid.
REQ-010 A bubble SHALL set ex_valid, ex_reg_file_write, ex_main_mem_write, ex_main_mem_read and ex_branch_control to 0 and all other ex_* outputs to 0; a bubble is therefore a no-op with no register write, no memory access and no branch.
REQ-011 Flush SHALL insert a bubble on the next edge regardless of hold or hazard, and SHALL increment bubble_count.
REQ-012 Hold without flush SHALL keep all ex_* outputs and bubble_count unchanged.
REQ-013 Load-use hazard SHALL equal ex_valid & ex_main_mem_read[3] & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)) & id_valid.
REQ-014 stall_out SHALL equal hazard & ~flush, driven combinationally in the same cycle.
REQ-015 When the hazard is set and neither flush nor hold is set, the next edge SHALL insert a bubble and increment bubble_count; the stalled ID instruction SHALL be captured on the following edge, since the hazard is cleared once EX holds the bubble.
REQ-016 bubble_count SHALL saturate at 16'hFFFF and never wrap.
REQ-017 A control word with id_valid = 0 SHALL be captured normally and is not counted as a bubble.
REQ-018 Latency SHALL be one cycle from ID inputs to ex_* outputs; the block SHALL contain no combinational path from id_* to ex_* outputs.

Reset
REQ-019 RESET low SHALL immediately, without waiting for CLK, clear all ex_* outputs, ex_valid and bubble_count to 0.
REQ-020 stall_out SHALL be 0 while RESET is low, because ex_valid is 0.
REQ-021 When RESET deasserts, the first rising CLK edge SHALL perform a normal priority-selected action.
REQ-022 RESET asserted mid-hold or mid-bubble SHALL discard the in-flight state completely.

Verification
REQ-023 Capture: id_valid=1, id_pc=32'h0000_0100, id_alu_signal=6'b001000, no flush/hold -> after one edge ex_pc=32'h100, ex_alu_signal=6'b001000, ex_valid=1, stall_out=0.
REQ-024 Load-use: EX holds a valid load (ex_main_mem_read=4'b1010, ex_rd=5) and ID has id_rs2=5 -> stall_out=1 in that cycle; the next edge gives ex_valid=0, ex_reg_file_write=0 and bubble_count=1; the edge after that captures the ID instruction.
REQ-025 No false hazard: an EX load with ex_rd=0 and id_rs1=0, or a non-load with ex_rd matching id_rs1 -> stall_out=0 and the instruction is captured normally.
REQ-026 Priority: flush=1, hold=1 and hazard all set together -> bubble inserted, stall_out=0, bubble_count+1; hold=1 alone for 3 cycles -> ex_* unchanged.
REQ-027 Saturation and reset: with bubble_count preloaded to 16'hFFFE, two flushes -> 16'hFFFF, then 16'hFFFF; pulsing RESET low between clock edges -> all outputs 0 immediately.
